// File: rtl/ws2812_serializer.sv
// WS2812 single-wire line driver: fetches one GRB word per LED and shifts
// it out MSB-first, prefetching the next LED while the current one is sent.
module ws2812_serializer #(
    parameter int N_LEDS   = 64,
    parameter int W_ADDR   = 6,
    parameter int TBIT_CYC = 125,
    parameter int T0H_CYC  = 40,
    parameter int T1H_CYC  = 80,
    parameter int TRST_CYC = 6000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [W_ADDR-1:0] leddata_addr,
    output logic              leddata_start,
    input  logic              leddata_done,
    input  logic [23:0]       leddata_color,
    output logic              ctrl,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);
    localparam int W_BIT = $clog2(TBIT_CYC);
    localparam int W_RST = $clog2(TRST_CYC);
    localparam int W_IDX = W_ADDR + 1;
    localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(TBIT_CYC - 1);
    localparam logic [W_RST-1:0] RST_LAST = W_RST'(TRST_CYC - 1);
    localparam logic [W_IDX-1:0] IDX_END  = W_IDX'(N_LEDS);
    localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_LEDS - 1);

    typedef enum logic [2:0] {POR_GAP, IDLE, SEND, WAIT_DATA, LATCH} state_t;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_REL} fstate_t;

    state_t           state;
    fstate_t          fstate;
    logic [W_RST-1:0] gap_cnt;
    logic [W_BIT-1:0] bit_cnt;
    logic [W_BIT-1:0] bit_cnt_nx;
    logic [4:0]       bit_idx;
    logic [W_IDX-1:0] led_idx;
    logic [W_IDX-1:0] fetch_idx;
    logic [23:0]      shift;
    logic [23:0]      nbuf;
    logic             nbuf_vld;
    logic             fetch_ok;

    function automatic logic [W_BIT-1:0] high_len(input logic b);
        return b ? W_BIT'(T1H_CYC) : W_BIT'(T0H_CYC);
    endfunction

    assign bit_cnt_nx = bit_cnt + W_BIT'(1);
    // Prefetch only inside a frame, one word ahead, never past the last LED
    assign fetch_ok = (state == SEND || state == WAIT_DATA) &&
                      !nbuf_vld && (fetch_idx < IDX_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= POR_GAP;
            fstate        <= F_IDLE;
            gap_cnt       <= '0;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            led_idx       <= '0;
            fetch_idx     <= '0;
            shift         <= '0;
            nbuf          <= '0;
            nbuf_vld      <= 1'b0;
            ctrl          <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
            leddata_start <= 1'b0;
            leddata_addr  <= '0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            unique case (state)
                POR_GAP: begin
                    ctrl <= 1'b0;
                    if (gap_cnt == RST_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + W_RST'(1);
                    end
                end
                IDLE: begin
                    if (enable) begin
                        busy      <= 1'b1;
                        led_idx   <= '0;
                        fetch_idx <= '0;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (nbuf_vld) begin
                        shift    <= nbuf;
                        nbuf_vld <= 1'b0;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        ctrl     <= high_len(nbuf[23]) != '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt != BIT_LAST) begin
                        bit_cnt <= bit_cnt_nx;
                        ctrl    <= bit_cnt_nx < high_len(shift[23]);
                    end else begin
                        bit_cnt <= '0;
                        if (bit_idx != 5'd23) begin
                            shift   <= {shift[22:0], 1'b0};
                            bit_idx <= bit_idx + 5'd1;
                            ctrl    <= high_len(shift[22]) != '0;
                        end else begin
                            bit_idx <= '0;
                            led_idx <= led_idx + W_IDX'(1);
                            if (led_idx == IDX_LAST) begin
                                ctrl    <= 1'b0;
                                gap_cnt <= '0;
                                state   <= LATCH;
                            end else if (nbuf_vld) begin
                                shift    <= nbuf;
                                nbuf_vld <= 1'b0;
                                ctrl     <= high_len(nbuf[23]) != '0;
                            end else begin
                                ctrl     <= 1'b0;
                                underrun <= 1'b1;
                                state    <= WAIT_DATA;
                            end
                        end
                    end
                end
                LATCH: begin
                    ctrl <= 1'b0;
                    if (gap_cnt == RST_LAST) begin
                        gap_cnt    <= '0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + W_RST'(1);
                    end
                end
                default: state <= POR_GAP;
            endcase

            // Request stays up with a frozen address until done is seen
            unique case (fstate)
                F_IDLE: begin
                    if (fetch_ok) begin
                        leddata_addr  <= fetch_idx[W_ADDR-1:0];
                        leddata_start <= 1'b1;
                        fstate        <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (leddata_done) begin
                        nbuf          <= leddata_color;
                        nbuf_vld      <= 1'b1;
                        leddata_start <= 1'b0;
                        fetch_idx     <= fetch_idx + W_IDX'(1);
                        fstate        <= F_REL;
                    end
                end
                F_REL:   fstate <= F_IDLE;
                default: fstate <= F_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: a randomized colour source plus a line
// decoder that rebuilds bits from pulse widths and checks them.
module tb_ws2812_serializer;
    localparam int N  = 2;
    localparam int WA = 6;
    localparam int TB = 125;
    localparam int T0 = 40;
    localparam int T1 = 80;
    localparam int TR = 6000;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [WA-1:0] leddata_addr;
    logic          leddata_start;
    logic          leddata_done  = 1'b0;
    logic [23:0]   leddata_color = 24'h0;
    logic          ctrl;
    logic          busy;
    logic          frame_done;
    logic          underrun;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [23:0] col [N] = '{24'hA50F01, 24'h000000};
    int frames = 0, n_under = 0, bits = 0, led = 0;
    int last_rise = 0, first_rise = 0, last_done = 0;
    int rst_cyc = 0, start_cyc = 0;
    bit need_lat = 1'b1, after_rst = 1'b0, uflag = 1'b0, prev_ctrl = 1'b0;
    int slow_dly = 2;
    int addr_log[$];
    int src_st = 0, src_cnt = 0, req_addr = 0;
    bit prev_start = 1'b0, spur = 1'b0;

    ws2812_serializer #(
        .N_LEDS(N), .W_ADDR(WA), .TBIT_CYC(TB),
        .T0H_CYC(T0), .T1H_CYC(T1), .TRST_CYC(TR)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .leddata_addr(leddata_addr), .leddata_start(leddata_start),
        .leddata_done(leddata_done), .leddata_color(leddata_color),
        .ctrl(ctrl), .busy(busy), .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int bound);
        int t = 0;
        while (frames < n && t < bound) begin
            @(posedge clk); #2;
            t++;
        end
        check("frame_tmo", 32'(frames >= n), 1);
    endtask

    // Colour source: answers each start edge after a delay, throws in
    // stray done pulses while no request is pending.
    always @(negedge clk) begin
        if (rst) begin
            leddata_done = 1'b0;
            src_st = 0;
            spur = 1'b0;
        end else begin
            if (spur) begin
                leddata_done = 1'b0;
                spur = 1'b0;
            end
            case (src_st)
                0: begin
                    if (leddata_start) begin
                        check("start_gap", 32'(prev_start), 0);
                        req_addr = int'(leddata_addr);
                        addr_log.push_back(req_addr);
                        start_cyc = cyc;
                        check("addr_rng", 32'(req_addr < N), 1);
                        src_cnt = (req_addr == 1) ? slow_dly : 2;
                        src_st = 1;
                    end else if ($urandom_range(0, 30) == 0) begin
                        leddata_done = 1'b1;
                        leddata_color = 24'($urandom);
                        spur = 1'b1;
                    end
                end
                1: begin
                    check("addr_hold", 32'(leddata_addr), req_addr);
                    check("start_hold", 32'(leddata_start), 1);
                    src_cnt--;
                    if (src_cnt <= 0) begin
                        leddata_done = 1'b1;
                        leddata_color = col[req_addr % N];
                        last_done = cyc;
                        src_st = 2;
                    end
                end
                default: begin
                    check("start_drop", 32'(leddata_start), 0);
                    leddata_done = 1'b0;
                    src_st = 0;
                end
            endcase
        end
        prev_start = leddata_start;
    end

    // Line decoder and frame-level reference model
    always @(negedge clk) begin
        if (rst) begin
            bits = 0;
            led = 0;
            need_lat = 1'b1;
            uflag = 1'b0;
            after_rst = 1'b1;
            rst_cyc = cyc + 1;
        end else begin
            if (ctrl && !prev_ctrl) begin
                if (after_rst) begin
                    check("por_gap", 32'(cyc - rst_cyc > TR), 1);
                    after_rst = 1'b0;
                end
                if (need_lat) begin
                    check("lat", cyc - last_done, 2);
                    need_lat = 1'b0;
                    if (bits == 0 && led == 0) first_rise = cyc;
                end else begin
                    check("period", cyc - last_rise, TB);
                end
                last_rise = cyc;
            end
            if (!ctrl && prev_ctrl) begin
                if (led < N)
                    check("hi_w", cyc - last_rise, col[led][23-bits] ? T1 : T0);
                else
                    check("extra_bit", led, N - 1);
                bits++;
                if (bits == 24) begin
                    bits = 0;
                    led++;
                end
            end
            if (underrun) begin
                n_under++;
                need_lat = 1'b1;
                uflag = 1'b1;
                check("u_mid", bits, 0);
            end
            if (frame_done) begin
                check("leds", led, N);
                check("gap", cyc - last_rise, TB + TR);
                if (!uflag)
                    check("flen", cyc - first_rise + 1, N * 24 * TB + TR + 1);
                frames++;
                led = 0;
                bits = 0;
                need_lat = 1'b1;
                uflag = 1'b0;
                foreach (col[i]) col[i] = 24'($urandom);
            end
        end
        prev_ctrl = ctrl;
    end

    initial begin
        int t;
        int n;
        rst = 1'b1;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("rst_ctrl", 32'(ctrl), 0);
        check("rst_start", 32'(leddata_start), 0);
        check("rst_addr", 32'(leddata_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fdone", 32'(frame_done), 0);
        check("rst_under", 32'(underrun), 0);

        rst = 1'b0;
        enable = 1'b1;
        wait_frames(2, 40000);
        t = 0;
        while (!(frames == 2 && led == 0 && bits == 5 && busy) && t < 3000) begin
            @(posedge clk); #2;
            t++;
        end
        check("bit5_tmo", 32'(t < 3000), 1);
        enable = 1'b0;
        wait_frames(3, 15000);
        repeat (200) @(posedge clk);
        #2;
        check("drop_busy", 32'(busy), 0);
        check("drop_frames", frames, 3);
        check("addr_cnt", addr_log.size(), 6);
        for (int i = 0; i < addr_log.size() && i < 6; i++)
            check("addr_seq", addr_log[i], i % 2);
        check("no_under", n_under, 0);

        slow_dly = 4000;
        enable = 1'b1;
        t = 0;
        while (!busy && t < 20) begin
            @(posedge clk); #2;
            t++;
        end
        check("busy_up", 32'(busy), 1);
        enable = 1'b0;
        wait_frames(4, 25000);
        check("under_cnt", n_under, 1);
        check("addr_cnt4", addr_log.size(), 8);
        slow_dly = 2;

        enable = 1'b1;
        t = 0;
        while (!(led == 0 && bits == 10 && busy) && t < 4000) begin
            @(posedge clk); #2;
            t++;
        end
        check("bit10_tmo", 32'(t < 4000), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_ctrl", 32'(ctrl), 0);
        check("mrst_start", 32'(leddata_start), 0);
        check("mrst_busy", 32'(busy), 0);
        rst = 1'b0;
        n = addr_log.size();
        t = 0;
        while (addr_log.size() == n && t < 8000) begin
            @(posedge clk); #2;
            t++;
        end
        check("refetch", 32'(addr_log.size() > n), 1);
        if (addr_log.size() > n) begin
            check("refetch_addr", addr_log[n], 0);
            check("refetch_gap", 32'(start_cyc - rst_cyc >= TR), 1);
        end
        enable = 1'b0;
        wait_frames(5, 15000);
        check("under_end", n_under, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
